fifo_sram_ctrl: RTL and testbench

Controller and arbiter for the shared BRAM-backed synchronous FIFO primitive (512 x DATA_WIDTH, 18Kb).
- Sequences the primitive's reset/flush: holds reset, then keeps the enables blocked while it settles.
- Round-robin arbitrates NUM_REQ producers onto the single write port.
- Gates the consumer's read enable and tracks occupancy.
- Sits between the producer/consumer logic and the primitive; it is the only driver of the primitive's RST/WREN/RDEN/DI.

---
 rtl/fifo_sram_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fifo_sram_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_ctrl.sv
// Controller/arbiter for the BRAM-backed FIFO primitive: reset sequencing, round-robin writes, gated reads.
// Optional consistency checker enabled by defining FIFO_SRAM_CTRL_CHECK_EN.
module fifo_sram_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int RST_HOLD   = 5,
    parameter int RST_SETTLE = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1),
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [IDX_W-1:0]              grant_id_o,
    input  logic                          deq_ready_i,
    output logic                          deq_valid_o,
    output logic                          rd_valid_o,
    output logic                          fifo_rst_o,
    output logic                          fifo_wren_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic                          fifo_rden_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_empty_i,
    output logic [CNT_W-1:0]              usage_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int CTR_MAX = (RST_HOLD > RST_SETTLE) ? RST_HOLD : RST_SETTLE;
    localparam int CTR_W   = (CTR_MAX > 1) ? $clog2(CTR_MAX) : 1;

    typedef enum logic [1:0] {HOLD, SETTLE, RUN} state_t;

    state_t                  state;
    logic [CTR_W-1:0]        count;
    logic [IDX_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]        usage;
    logic                    rd_valid;

    logic                    run;
    logic                    write_ok;
    logic                    found;
    logic [IDX_W-1:0]        grant_idx;
    logic [IDX_W-1:0]        cand;
    logic [NUM_REQ-1:0]      grant;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    deq_valid;
    logic                    rden;

    assign run      = (state == RUN);
    assign write_ok = run && !flush_i && !fifo_full_i && (usage != CNT_W'(DEPTH));

    // Search starts at the round-robin pointer and wraps, so the first valid producer after the last winner gets the port.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        if (write_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
                if (!found && req_valid_i[cand]) begin
                    found       = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                wdata = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign deq_valid = run && !flush_i && !fifo_empty_i && (usage != '0);
    assign rden      = deq_valid && deq_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= HOLD;
            count    <= CTR_W'(RST_HOLD - 1);
            rr_ptr   <= '0;
            usage    <= '0;
            rd_valid <= 1'b0;
        end else if (flush_i) begin
            state    <= HOLD;
            count    <= CTR_W'(RST_HOLD - 1);
            usage    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rden;
            case (state)
                HOLD: begin
                    if (count == '0) begin
                        state <= SETTLE;
                        count <= CTR_W'(RST_SETTLE - 1);
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                SETTLE: begin
                    if (count == '0) begin
                        state <= RUN;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    if (found) begin
                        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                    case ({found, rden})
                        2'b10:   usage <= usage + 1'b1;
                        2'b01:   usage <= usage - 1'b1;
                        default: usage <= usage;
                    endcase
                end
            endcase
        end
    end

`ifdef FIFO_SRAM_CTRL_CHECK_EN
    logic err;
    logic act_q;

    // Flags are only compared once a cycle has passed with no enable, giving the primitive time to update them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err   <= 1'b0;
            act_q <= 1'b0;
        end else if (flush_i) begin
            err   <= 1'b0;
            act_q <= 1'b0;
        end else begin
            act_q <= found || rden;
            if (run && !act_q &&
                ((fifo_full_i != (usage == CNT_W'(DEPTH))) || (fifo_empty_i != (usage == '0)))) begin
                err <= 1'b1;
            end
        end
    end

    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

    assign req_ready_o  = grant;
    assign grant_id_o   = grant_idx;
    assign fifo_wren_o  = found;
    assign fifo_wdata_o = wdata;
    assign deq_valid_o  = deq_valid;
    assign fifo_rden_o  = rden;
    assign rd_valid_o   = rd_valid;
    assign fifo_rst_o   = (state == HOLD);
    assign busy_o       = !run;
    assign usage_o      = usage;

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Self-checking bench for fifo_sram_ctrl: queue-based primitive, phase/pointer/count reference model.
module tb_fifo_sram_ctrl;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 512;
    localparam int RST_HOLD   = 5;
    localparam int RST_SETTLE = 4;
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int IDX_W      = $clog2(NUM_REQ);

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic                          flush_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [IDX_W-1:0]              grant_id_o;
    logic                          deq_ready_i;
    logic                          deq_valid_o;
    logic                          rd_valid_o;
    logic                          fifo_rst_o;
    logic                          fifo_wren_o;
    logic [DATA_WIDTH-1:0]         fifo_wdata_o;
    logic                          fifo_rden_o;
    logic                          fifo_full_i;
    logic                          fifo_empty_i;
    logic [CNT_W-1:0]              usage_o;
    logic                          busy_o;
    logic                          err_o;

    fifo_sram_ctrl #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
        .RST_HOLD(RST_HOLD), .RST_SETTLE(RST_SETTLE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o), .grant_id_o(grant_id_o),
        .deq_ready_i(deq_ready_i), .deq_valid_o(deq_valid_o), .rd_valid_o(rd_valid_o),
        .fifo_rst_o(fifo_rst_o), .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o),
        .fifo_rden_o(fifo_rden_o), .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
        .usage_o(usage_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset/flush release, next round-robin start, expected count.
    int phase_cnt    = 0;
    int rr_next      = 0;
    int exp_usage    = 0;
    bit exp_rd_valid = 1'b0;
    logic [DATA_WIDTH-1:0] prim_q[$];

    logic                  last_rst, last_busy, last_wren, last_rden, last_deq_valid, last_rd_valid;
    logic [NUM_REQ-1:0]    last_ready;
    logic [IDX_W-1:0]      last_grant_id;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus();
        int                    g;
        bit                    run, full, empty, exp_deq, exp_rden;
        logic [NUM_REQ-1:0]    exp_ready;
        logic [DATA_WIDTH-1:0] exp_wdata;
        logic                  act_rst, act_wren, act_rden;
        logic [DATA_WIDTH-1:0] act_wdata;

        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = $urandom();
        end
        full         = (prim_q.size() >= DEPTH);
        empty        = (prim_q.size() == 0);
        fifo_full_i  = full;
        fifo_empty_i = empty;
        #1;

        run       = !rst_i && (phase_cnt >= RST_HOLD + RST_SETTLE);
        g         = -1;
        exp_ready = '0;
        exp_wdata = '0;
        if (run && !flush_i && !full && exp_usage != DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (rr_next + k) % NUM_REQ;
                if (g < 0 && req_valid_i[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            exp_wdata    = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
        end
        exp_deq  = run && !flush_i && !empty && exp_usage != 0;
        exp_rden = exp_deq && deq_ready_i;

        check_output("fifo_rst", fifo_rst_o, (rst_i || phase_cnt < RST_HOLD) ? 1 : 0);
        check_output("busy", busy_o, !run);
        check_output("req_ready", req_ready_o, exp_ready);
        check_output("grant_id", grant_id_o, (g >= 0) ? g : 0);
        check_output("wren", fifo_wren_o, g >= 0);
        check_output("wdata", fifo_wdata_o, exp_wdata);
        check_output("deq_valid", deq_valid_o, exp_deq);
        check_output("rden", fifo_rden_o, exp_rden);
        check_output("rd_valid", rd_valid_o, rst_i ? 1'b0 : exp_rd_valid);
        check_output("usage", usage_o, rst_i ? 0 : exp_usage);
        check_output("err", err_o, 0);

        last_rst       = fifo_rst_o;
        last_busy      = busy_o;
        last_wren      = fifo_wren_o;
        last_rden      = fifo_rden_o;
        last_deq_valid = deq_valid_o;
        last_rd_valid  = rd_valid_o;
        last_ready     = req_ready_o;
        last_grant_id  = grant_id_o;
        act_rst        = fifo_rst_o;
        act_wren       = fifo_wren_o;
        act_rden       = fifo_rden_o;
        act_wdata      = fifo_wdata_o;

        @(posedge clk_i);
        if (rst_i) begin
            phase_cnt    = 0;
            rr_next      = 0;
            exp_usage    = 0;
            exp_rd_valid = 1'b0;
            prim_q.delete();
        end else begin
            if (act_rst) begin
                prim_q.delete();
            end else begin
                if (act_rden && prim_q.size() > 0) void'(prim_q.pop_front());
                if (act_wren) prim_q.push_back(act_wdata);
            end
            if (flush_i) begin
                phase_cnt    = 0;
                exp_usage    = 0;
                exp_rd_valid = 1'b0;
            end else begin
                if (phase_cnt < 1000) phase_cnt++;
                if (g >= 0) rr_next = (g + 1) % NUM_REQ;
                if (g >= 0 && !exp_rden) exp_usage++;
                else if (g < 0 && exp_rden) exp_usage--;
                exp_rd_valid = exp_rden;
            end
        end
        @(negedge clk_i);
    endtask

    initial begin
        int ptr_before;
        int n;
        rst_i        = 1'b1;
        flush_i      = 1'b0;
        req_valid_i  = '0;
        req_data_i   = '0;
        deq_ready_i  = 1'b0;
        fifo_full_i  = 1'b0;
        fifo_empty_i = 1'b1;
        @(negedge clk_i);

        // Reset, then the hold/settle sequence
        for (int i = 0; i < 3; i++) begin
            req_valid_i = NUM_REQ'($urandom());
            deq_ready_i = 1'($urandom());
            apply_stimulus();
        end
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid_i = (i == 9) ? '0 : NUM_REQ'($urandom());
            deq_ready_i = (i == 9) ? 1'b0 : 1'($urandom());
            apply_stimulus();
            check_output("seq_rst", last_rst, (i < RST_HOLD) ? 1 : 0);
            check_output("seq_busy", last_busy, (i < 9) ? 1 : 0);
        end

        // All producers valid: strict rotation
        req_valid_i = '1;
        deq_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus();
            check_output("rr_grant", last_grant_id, i % 4);
        end
        check_output("rr_usage", usage_o, 8);

        // Sparse producers 1 and 3
        req_valid_i = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_output("sparse_grant", last_grant_id, (i % 2 == 0) ? 1 : 3);
        end

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            req_valid_i = NUM_REQ'($urandom());
            deq_ready_i = 1'($urandom());
            apply_stimulus();
        end

        // Fill to the full boundary
        req_valid_i = '1;
        deq_ready_i = 1'b0;
        n = 0;
        while (exp_usage < DEPTH && n < 700) begin
            apply_stimulus();
            n++;
        end
        check_output("fill_usage", usage_o, DEPTH);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("full_ready", last_ready, 0);
        end
        deq_ready_i = 1'b1;
        apply_stimulus();
        check_output("full_pop_rden", last_rden, 1);
        check_output("full_pop_wren", last_wren, 0);
        check_output("full_pop_usage", usage_o, DEPTH - 1);
        deq_ready_i = 1'b0;
        apply_stimulus();
        check_output("refill_wren", last_wren, 1);
        check_output("refill_usage", usage_o, DEPTH);

        // Read latency from usage 2
        req_valid_i = '0;
        flush_i     = 1'b1;
        apply_stimulus();
        flush_i = 1'b0;
        for (int i = 0; i < 9; i++) apply_stimulus();
        req_valid_i = 4'b0001;
        apply_stimulus();
        apply_stimulus();
        check_output("rd_usage2", usage_o, 2);
        req_valid_i = '0;
        deq_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output("rd_rden", last_rden, (i < 2) ? 1 : 0);
            check_output("rd_rdvalid", last_rd_valid, (i > 0) ? 1 : 0);
        end
        check_output("rd_deq_valid", last_deq_valid, 0);
        deq_ready_i = 1'b0;
        apply_stimulus();
        check_output("rd_usage0", usage_o, 0);

        // Flush with usage 100 and all producers valid
        req_valid_i = '1;
        for (int i = 0; i < 100; i++) apply_stimulus();
        check_output("pre_flush_usage", usage_o, 100);
        ptr_before  = rr_next;
        flush_i     = 1'b1;
        deq_ready_i = 1'b1;
        apply_stimulus();
        check_output("flush_wren", last_wren, 0);
        check_output("flush_rden", last_rden, 0);
        flush_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus();
            check_output("flush_seq_rst", last_rst, (i < RST_HOLD) ? 1 : 0);
            check_output("flush_usage", usage_o, 0);
        end
        deq_ready_i = 1'b0;
        apply_stimulus();
        check_output("resume_wren", last_wren, 1);
        check_output("resume_grant", last_grant_id, ptr_before);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
